// File: rtl/ecc_chan_pkg.sv
// ecc_chan_pkg: shared types and constants for the ECC channel error injector.
//   inj_mode_t       - injection mode encoding (NONE, SINGLE, DOUBLE, RANDOM)
//   LFSR_TAPS        - Galois feedback mask for x^16+x^14+x^13+x^11+1
//   DEFAULT_CW_WIDTH - default codeword width
//   lfsr_step()      - one Galois shift step of the 16-bit LFSR
package ecc_chan_pkg;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'd0,
    INJ_SINGLE = 2'd1,
    INJ_DOUBLE = 2'd2,
    INJ_RANDOM = 2'd3
  } inj_mode_t;

  localparam logic [15:0] LFSR_TAPS        = 16'hB400;
  localparam int          DEFAULT_CW_WIDTH = 13;

  // Right-shifting Galois step: the bit shifted out selects the tap XOR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ecc_lfsr16.sv
// ecc_lfsr16: 16-bit Galois LFSR used to pick random flip positions.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, loads seed
//   adv  - advance one step this cycle
//   seed - reset value (must be nonzero)
//   q    - current LFSR state
module ecc_lfsr16
  import ecc_chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] state_r;

  // LFSR state register: seed on reset, one step per advance request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= seed;
    end else if (adv) begin
      state_r <= lfsr_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign q = state_r;

endmodule

// File: rtl/ecc_channel_injector.sv
// ecc_channel_injector: FIFO between the ECC encoder and decoder that applies
// programmable bit flips to each accepted codeword.
// Optional feature: define ECC_CHAN_STATS_EN to implement the saturating
// inj_count register; otherwise inj_count is tied to zero.
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   in_valid/in_codeword     - upstream word; in_ready when FIFO not full
//   inj_mode                 - 0 NONE, 1 SINGLE, 2 DOUBLE, 3 RANDOM
//   inj_pos_a, inj_pos_b     - flip positions (b used by DOUBLE only)
//   inj_every                - inject on every Nth accepted word, 0 = never
//   out_valid/out_ready      - downstream handshake for the head entry
//   out_codeword             - head word with flips applied
//   out_flip_mask            - bits flipped in the head word
//   out_injected             - head mask is nonzero
//   count                    - FIFO occupancy
//   inj_count                - words injected (saturating)
module ecc_channel_injector
  import ecc_chan_pkg::*;
#(
  parameter int          CW_WIDTH  = DEFAULT_CW_WIDTH,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CW_WIDTH-1:0]        in_codeword,
  output logic                       in_ready,
  input  logic [1:0]                 inj_mode,
  input  logic [3:0]                 inj_pos_a,
  input  logic [3:0]                 inj_pos_b,
  input  logic [7:0]                 inj_every,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW_WIDTH-1:0]        out_codeword,
  output logic [CW_WIDTH-1:0]        out_flip_mask,
  output logic                       out_injected,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                inj_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CW_WIDTH-1:0] mem_cw_r   [DEPTH];
  logic [CW_WIDTH-1:0] mem_mask_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [7:0]          cad_r;

  logic                in_ready_s;
  logic                out_valid_s;
  logic                push_s;
  logic                pop_s;
  logic                cad_active_s;
  logic                sel_s;
  logic [CW_WIDTH-1:0] mask_s;
  logic [15:0]         lfsr_q_s;
  logic [7:0]          rnd_pos_s;
  inj_mode_t           mode_s;
  logic                unused_lfsr_hi_s;

  // One-hot bit at pos; a shift past the top leaves zero, so out-of-range
  // positions contribute nothing.
  function automatic logic [CW_WIDTH-1:0] pos_bit(input logic [7:0] pos);
    return {{(CW_WIDTH-1){1'b0}}, 1'b1} << pos;
  endfunction

  assign mode_s      = inj_mode_t'(inj_mode);
  assign in_ready_s  = (count_r != CNT_W'(DEPTH));
  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  // A full FIFO never pushes, even when the head pops in the same cycle.
  assign push_s      = in_valid && in_ready_s;
  assign pop_s       = out_valid_s && out_ready;

  assign cad_active_s = (mode_s != INJ_NONE) && (inj_every != 8'd0);
  assign sel_s        = cad_active_s && (cad_r == (inj_every - 8'd1));

  // Random position uses the LFSR value before this accept advances it.
  assign rnd_pos_s        = lfsr_q_s[7:0] % 8'(CW_WIDTH);
  assign unused_lfsr_hi_s = ^lfsr_q_s[15:8];

  ecc_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (push_s),
    .seed (LFSR_SEED),
    .q    (lfsr_q_s)
  );

  // Flip mask for the word being accepted this cycle.
  always_comb begin
    mask_s = {CW_WIDTH{1'b0}};
    if (sel_s) begin
      case (mode_s)
        INJ_SINGLE: mask_s = pos_bit({4'd0, inj_pos_a});
        INJ_DOUBLE: mask_s = pos_bit({4'd0, inj_pos_a}) | pos_bit({4'd0, inj_pos_b});
        INJ_RANDOM: mask_s = pos_bit(rnd_pos_s);
        default:    mask_s = {CW_WIDTH{1'b0}};
      endcase
    end else begin
      mask_s = {CW_WIDTH{1'b0}};
    end
  end

  // FIFO storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_cw_r[wr_ptr_r]   <= in_codeword ^ mask_s;
      mem_mask_r[wr_ptr_r] <= mask_s;
    end else begin
      mem_cw_r[wr_ptr_r]   <= mem_cw_r[wr_ptr_r];
      mem_mask_r[wr_ptr_r] <= mem_mask_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Cadence counter: cleared whenever injection is inactive, wraps on selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cad_r <= 8'd0;
    end else if (!cad_active_s) begin
      cad_r <= 8'd0;
    end else if (push_s) begin
      cad_r <= sel_s ? 8'd0 : (cad_r + 8'd1);
    end else begin
      cad_r <= cad_r;
    end
  end

`ifdef ECC_CHAN_STATS_EN
  logic [15:0] inj_cnt_r;

  // Saturating count of accepted words that carried a nonzero mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_cnt_r <= 16'h0000;
    end else if (push_s && (mask_s != {CW_WIDTH{1'b0}}) && (inj_cnt_r != 16'hFFFF)) begin
      inj_cnt_r <= inj_cnt_r + 16'd1;
    end else begin
      inj_cnt_r <= inj_cnt_r;
    end
  end

  assign inj_count = inj_cnt_r;
`else
  assign inj_count = 16'h0000;
`endif

  // Outputs read only registered state and are forced to zero when empty.
  assign in_ready      = in_ready_s;
  assign out_valid     = out_valid_s;
  assign count         = count_r;
  assign out_codeword  = out_valid_s ? mem_cw_r[rd_ptr_r]   : {CW_WIDTH{1'b0}};
  assign out_flip_mask = out_valid_s ? mem_mask_r[rd_ptr_r] : {CW_WIDTH{1'b0}};
  assign out_injected  = (out_flip_mask != {CW_WIDTH{1'b0}});

endmodule

// File: tb/tb_ecc_channel_injector.sv
// tb_ecc_channel_injector: directed self-checking bench for ecc_channel_injector
// with a scoreboard queue of expected head entries.
module tb_ecc_channel_injector;

`ifdef ECC_CHAN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [12:0] in_codeword = 13'd0;
  logic        in_ready;
  logic [1:0]  inj_mode = 2'd0;
  logic [3:0]  inj_pos_a = 4'd0;
  logic [3:0]  inj_pos_b = 4'd0;
  logic [7:0]  inj_every = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [12:0] out_codeword;
  logic [12:0] out_flip_mask;
  logic        out_injected;
  logic [3:0]  count;
  logic [15:0] inj_count;

  ecc_channel_injector #(.CW_WIDTH(13), .DEPTH(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_codeword(in_codeword),
    .in_ready(in_ready), .inj_mode(inj_mode), .inj_pos_a(inj_pos_a),
    .inj_pos_b(inj_pos_b), .inj_every(inj_every), .out_valid(out_valid),
    .out_ready(out_ready), .out_codeword(out_codeword),
    .out_flip_mask(out_flip_mask), .out_injected(out_injected),
    .count(count), .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] cw;
    logic [12:0] mask;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0]  m_cad = 8'd0;
  int          m_inj = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference mask built position by position from the mode definition.
  function automatic logic [12:0] model_mask(input logic [1:0] m, input logic [3:0] a,
                                             input logic [3:0] b, input logic [15:0] l);
    logic [12:0] r;
    int rp;
    r = 13'd0;
    rp = int'(l[7:0]) % 13;
    for (int i = 0; i < 13; i++) begin
      case (m)
        2'd1:    if (i == int'(a)) r[i] = 1'b1;
        2'd2:    if (i == int'(a) || i == int'(b)) r[i] = 1'b1;
        2'd3:    if (i == rp) r[i] = 1'b1;
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic logic [15:0] model_lfsr(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model_clear();
    sb_q.delete();
    m_lfsr = 16'hACE1;
    m_cad  = 8'd0;
    m_inj  = 0;
  endtask

  // Offer one word, wait (bounded) for in_ready, accept it and record expectation.
  task automatic send(input logic [12:0] cw);
    int guard;
    logic sel;
    logic [12:0] mk;
    exp_t e;
    guard = 0;
    in_valid = 1'b1;
    in_codeword = cw;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      if (inj_mode != 2'd0 && inj_every != 8'd0) begin
        sel = (m_cad == inj_every - 8'd1);
        m_cad = sel ? 8'd0 : m_cad + 8'd1;
      end else begin
        sel = 1'b0;
        m_cad = 8'd0;
      end
      mk = sel ? model_mask(inj_mode, inj_pos_a, inj_pos_b, m_lfsr) : 13'd0;
      m_lfsr = model_lfsr(m_lfsr);
      @(posedge clk); #1;
      e.cw = cw ^ mk;
      e.mask = mk;
      sb_q.push_back(e);
      if (mk != 13'd0) m_inj++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while ((out_valid || sb_q.size() != 0) && g < 30) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  // Scoreboard: head of the DUT must always match the front of the queue.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("count", 32'(count), 32'(sb_q.size()));
      chk("in_ready", 32'(in_ready), (sb_q.size() != 8) ? 32'd1 : 32'd0);
      chk("inj_count", 32'(inj_count), STATS ? 32'(m_inj) : 32'd0);
      if (sb_q.size() != 0) begin
        chk("head_valid", 32'(out_valid), 32'd1);
        chk("head_cw", 32'(out_codeword), 32'(sb_q[0].cw));
        chk("head_mask", 32'(out_flip_mask), 32'(sb_q[0].mask));
        chk("head_inj", 32'(out_injected), (sb_q[0].mask != 13'd0) ? 32'd1 : 32'd0);
        if (out_ready) void'(sb_q.pop_front());
      end else begin
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_cw", 32'(out_codeword), 32'd0);
        chk("idle_mask", 32'(out_flip_mask), 32'd0);
      end
    end
  end

  initial begin
    // Power-on reset and reset-state checks.
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_injcnt", 32'(inj_count), 32'd0);
    chk("rst_cw", 32'(out_codeword), 32'd0);
    chk_en = 1'b1;

    // Passthrough at full rate.
    inj_mode = 2'd0;
    inj_every = 8'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(13'h0A5A ^ 13'(i * 13'h111));
    drain();

    // Full / empty.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(13'h1000 | 13'(i));
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_codeword = 13'h1FFF;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("full_hold", 32'(count), 32'd8);
    drain();

    // SINGLE every third word.
    inj_mode = 2'd1;
    inj_pos_a = 4'd5;
    inj_every = 8'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(13'h0000);
    drain();
    chk("single_injcnt", 32'(inj_count), STATS ? 32'd2 : 32'd0);

    // DOUBLE cases, head observed with out_ready low.
    inj_mode = 2'd2;
    inj_every = 8'd1;
    out_ready = 1'b0;
    inj_pos_a = 4'd0; inj_pos_b = 4'd12;
    send(13'h0000);
    chk("dbl_0_12", 32'(out_codeword), 32'h1001);
    drain();
    out_ready = 1'b0;
    inj_pos_a = 4'd4; inj_pos_b = 4'd4;
    send(13'h0000);
    chk("dbl_4_4", 32'(out_codeword), 32'h0010);
    drain();
    out_ready = 1'b0;
    inj_pos_a = 4'd14; inj_pos_b = 4'd15;
    send(13'h0ABC);
    chk("dbl_oor_mask", 32'(out_flip_mask), 32'd0);
    chk("dbl_oor_inj", 32'(out_injected), 32'd0);
    chk("dbl_oor_injcnt", 32'(inj_count), STATS ? 32'd4 : 32'd0);
    drain();

    // RANDOM from a fresh reset.
    do_reset();
    inj_mode = 2'd3;
    inj_every = 8'd1;
    out_ready = 1'b0;
    send(13'h0000);
    chk("rand_first", 32'(out_flip_mask), 32'h0010);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(13'h0F0F ^ 13'(i));
    drain();

    // Asynchronous reset with a partly filled FIFO.
    do_reset();
    out_ready = 1'b0;
    inj_mode = 2'd3;
    for (int i = 0; i < 3; i++) send(13'(i + 1));
    inj_mode = 2'd0;
    for (int i = 0; i < 2; i++) send(13'h0100);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_injcnt", 32'(inj_count), STATS ? 32'd3 : 32'd0);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_cw", 32'(out_codeword), 32'd0);
    chk("arst_mask", 32'(out_flip_mask), 32'd0);
    chk("arst_inj", 32'(out_injected), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_injcnt", 32'(inj_count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    inj_mode = 2'd3;
    inj_every = 8'd1;
    send(13'h0000);
    chk("post_rst_rand", 32'(out_flip_mask), 32'h0010);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
